// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DRAIN,
      S_DONE,
      S_ERROR
   } state_e;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int ADDR_STRIDE    = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if;

   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        wr_en_o;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;

   modport slave (
      input  byte_valid_i,
      input  byte_data_i,
      output byte_ready_o,
      output wr_en_o,
      output wr_addr_o,
      output wr_data_o
   );

   modport master (
      output byte_valid_i,
      output byte_data_i,
      input  byte_ready_o,
      input  wr_en_o,
      input  wr_addr_o,
      input  wr_data_o
   );

endinterface

// File: rtl/word_assembler.sv
// Big-endian 8->32 assembler; word_valid_o flags the 4th byte of a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_en_i) begin
         shift_d = {shift_q[15:0], byte_i};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign word_o       = {shift_q, byte_i};
   assign word_valid_o = byte_en_i && !clear_i &&
                         (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a program image into instruction memory, holding the core in reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module program_loader
   import loader_pkg::*;
#(
   parameter int MEMORY_DEPTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   program_loader_if.slave  bus,
   output logic             cpu_reset_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o
);

   localparam int IW = $clog2(MEMORY_DEPTH) + 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_e TAIL_ST = S_CHECK;
`else
   localparam state_e TAIL_ST = S_DRAIN;
`endif

   state_e          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            wr_en_q, wr_en_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [31:0]     wr_data_q, wr_data_d;
   logic            ready, xfer, clr;
   logic            asm_en, word_valid, last_word;
   logic [31:0]     word;
   logic [15:0]     n_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   assign ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA) || (state_q == S_CHECK);
   assign xfer  = bus.byte_valid_i && ready;
   assign asm_en = xfer && (state_q == S_DATA);
   assign n_full = {len_q[15:8], bus.byte_data_i};
   assign last_word = (16'(idx_q) + 16'd1) == len_q;

   word_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clr),
      .byte_en_i    (asm_en),
      .byte_i       (bus.byte_data_i),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      clr       = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d = S_LEN_HI;
               len_d   = '0;
               idx_d   = '0;
               clr     = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = bus.byte_data_i;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d = n_full;
               if (n_full > 16'(MEMORY_DEPTH)) state_d = S_ERROR;
               else if (n_full == 16'd0)       state_d = TAIL_ST;
               else                            state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.byte_data_i;
`endif
               if (word_valid) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = 32'(idx_q) * 32'(ADDR_STRIDE);
                  wr_data_d = word;
                  idx_d     = idx_q + IW'(1);
                  if (last_word) state_d = TAIL_ST;
               end
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               state_d = (bus.byte_data_i == csum_q) ? S_DRAIN : S_ERROR;
            end
         end
`endif
         // Extra cycle so the last write lands before the core wakes.
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign bus.byte_ready_o = ready;
   assign bus.wr_en_o      = wr_en_q;
   assign bus.wr_addr_o    = wr_addr_q;
   assign bus.wr_data_o    = wr_data_q;
   assign cpu_reset_o      = (state_q == S_DONE);
   assign done_o           = (state_q == S_DONE);
   assign error_o          = (state_q == S_ERROR);
   assign busy_o           = ready || (state_q == S_DRAIN);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a stream-level write scoreboard.
module tb_program_loader;

   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_i = 1'b0;
   logic cpu_reset, busy, done, error;

   program_loader_if bus();

   program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .bus         (bus),
      .cpu_reset_o (cpu_reset),
      .busy_o      (busy),
      .done_o      (done),
      .error_o     (error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [63:0] expq[$];
   logic [63:0] wlog[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected write.
   always @(negedge clk) begin
      logic [63:0] e;
      if (bus.wr_en_o === 1'b1) begin
         wlog.push_back({bus.wr_addr_o, bus.wr_data_o});
         if (expq.size() == 0) begin
            check("unexpected_write", {31'd0, bus.wr_en_o}, 32'd0);
         end else begin
            e = expq.pop_front();
            check("wr_addr", bus.wr_addr_o, e[63:32]);
            check("wr_data", bus.wr_data_o, e[31:0]);
         end
      end
      check("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, done});
      check("ready_without_busy",
            {31'd0, bus.byte_ready_o & ~busy}, 32'd0);
      check("done_and_error", {31'd0, done & error}, 32'd0);
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},  {31'd0, bus.byte_ready_o}, 32'd0);
      check({tag, "_wr_en"},  {31'd0, bus.wr_en_o}, 32'd0);
      check({tag, "_wr_addr"}, bus.wr_addr_o, 32'd0);
      check({tag, "_wr_data"}, bus.wr_data_o, 32'd0);
      check({tag, "_cpu_rst"}, {31'd0, cpu_reset}, 32'd0);
      check({tag, "_busy"},   {31'd0, busy}, 32'd0);
      check({tag, "_done"},   {31'd0, done}, 32'd0);
      check({tag, "_error"},  {31'd0, error}, 32'd0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Leaves the bench on the negedge right after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      t = 0;
      if (gap) begin
         bus.byte_valid_i = 1'b0;
         @(negedge clk);
      end
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = b;
      while (!bus.byte_ready_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.byte_ready_o) begin
         check("ready_timeout", {31'd0, bus.byte_ready_o}, 32'd1);
         bus.byte_valid_i = 1'b0;
         return;
      end
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
   endtask

   // Model: writes and outcome follow from the stream contents alone.
   task automatic model_writes(input logic [7:0] s[$], input int sent);
      int n;
      n = {s[0], s[1]};
      if (n > DEPTH) return;
      for (int k = 0; k < n; k++) begin
         if (2 + 4 * k + 3 < sent)
            expq.push_back({32'(k * 4), s[2+4*k], s[3+4*k],
                            s[4+4*k], s[5+4*k]});
      end
   endtask

   function automatic void add_csum(inout logic [7:0] s[$],
                                    input logic [7:0] flip);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < s.size(); i++) x ^= s[i];
      s.push_back(x ^ flip);
`else
      s = s;
      flip = flip;
`endif
   endfunction

   task automatic run_stream(input logic [7:0] s[$], input bit gap,
                             input string tag);
      int  n;
      int  nsend;
      bit  ed, ee;
      n  = {s[0], s[1]};
      ee = (n > DEPTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (!ee) begin
         logic [7:0] x;
         x = 8'h00;
         for (int i = 2; i < 2 + 4 * n; i++) x ^= s[i];
         ee = (x != s[2+4*n]);
      end
`endif
      ed    = !ee;
      nsend = (n > DEPTH) ? 2 : s.size();
      wlog.delete();
      model_writes(s, nsend);
      do_start();
      for (int i = 0; i < nsend; i++) send_byte(s[i], gap);
      if (ed) begin
         check({tag, "_drain_cpu_rst"}, {31'd0, cpu_reset}, 32'd0);
         check({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
         @(negedge clk);
         check({tag, "_release"}, {31'd0, cpu_reset}, 32'd1);
      end else begin
         check({tag, "_err_now"}, {31'd0, error}, 32'd1);
         check({tag, "_err_cpu_rst"}, {31'd0, cpu_reset}, 32'd0);
      end
      repeat (2) @(negedge clk);
      check({tag, "_pending"}, 32'(expq.size()), 32'd0);
      check({tag, "_done"}, {31'd0, done}, {31'd0, ed});
      check({tag, "_error"}, {31'd0, error}, {31'd0, ee});
      check({tag, "_ready"}, {31'd0, bus.byte_ready_o}, 32'd0);
   endtask

   initial begin
      logic [7:0] s[$];
      logic [7:0] p[$];
      int nw;

      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s[$];
      logic [7:0] p[$];

      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b1;
      @(negedge clk);

      // N=2 full rate
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h01, 8'h09, 8'h50, 8'h20};
      add_csum(s, 8'h00);
      run_stream(s, 1'b0, "n2");
      check("n2_nwrites", 32'(wlog.size()), 32'd2);
      if (wlog.size() >= 2) begin
         check("n2_w0_addr", wlog[0][63:32], 32'h0);
         check("n2_w0_data", wlog[0][31:0], 32'h20080005);
         check("n2_w1_addr", wlog[1][63:32], 32'h4);
         check("n2_w1_data", wlog[1][31:0], 32'h01095020);
      end
      check("n2_hold_addr", bus.wr_addr_o, 32'h4);
      check("n2_hold_data", bus.wr_data_o, 32'h01095020);

      // Same stream with valid toggling
      run_stream(s, 1'b1, "n2gap");
      check("n2gap_nwrites", 32'(wlog.size()), 32'd2);

      // Empty image
      s = '{8'h00, 8'h00};
      add_csum(s, 8'h00);
      run_stream(s, 1'b0, "n0");
      check("n0_nwrites", 32'(wlog.size()), 32'd0);

      // Oversized image
      s = '{8'h00, 8'h21};
      run_stream(s, 1'b0, "big");
      check("big_nwrites", 32'(wlog.size()), 32'd0);
      check("big_cpu_rst", {31'd0, cpu_reset}, 32'd0);

      // Exactly MEMORY_DEPTH words
      s = '{8'h00, 8'h20};
      for (int k = 0; k < DEPTH * 4; k++) s.push_back(8'(k * 7 + 3));
      add_csum(s, 8'h00);
      run_stream(s, 1'b0, "full");
      check("full_nwrites", 32'(wlog.size()), 32'(DEPTH));
      check("full_last_addr", bus.wr_addr_o, 32'h7C);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      add_csum(s, 8'h01);
      check("cs_bad_byte", {24'd0, s[6]}, 32'h45);
      run_stream(s, 1'b0, "csbad");
      check("csbad_nwrites", 32'(wlog.size()), 32'd1);
      check("csbad_addr", bus.wr_addr_o, 32'h0);
      check("csbad_data", bus.wr_data_o, 32'h11223344);
      s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      add_csum(s, 8'h00);
      run_stream(s, 1'b0, "csgood");
      check("csgood_done", {31'd0, done}, 32'd1);
`endif

      // Reset in the middle of the data phase
      p = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
      wlog.delete();
      model_writes(p, p.size());
      do_start();
      foreach (p[i]) send_byte(p[i], 1'b0);
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check_reset_values("mid");
      reset = 1'b1;
      check("mid_nwrites", 32'(wlog.size()), 32'd1);
      check("mid_pending", 32'(expq.size()), 32'd0);
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h01, 8'h09, 8'h50, 8'h20};
      add_csum(s, 8'h00);
      run_stream(s, 1'b0, "after");
      if (wlog.size() >= 1)
         check("after_w0_addr", wlog[0][63:32], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
